// File: rtl/fifo_sync_pkg.sv
// Shared helpers and default thresholds for the single-clock FIFO family.
package fifo_sync_pkg;

    localparam int AE_THRESH_DEF = 2;
    // Default almost-full sits this many entries below DEPTH.
    localparam int AF_MARGIN_DEF = 2;

    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrapping storage pointer for fifo_sync_flags; counts 0..DEPTH-1 for any DEPTH.
module fifo_sync_ptr
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Inc,
    output logic [PW-1:0] Ptr
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Ptr <= '0;
        end else if (Inc) begin
            Ptr <= PW'(ptr_next(32'(Ptr), unsigned'(DEPTH)));
        end
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with level, threshold flags and overflow/underflow pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through read data.
module fifo_sync_flags
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AF_THRESH  = DEPTH - AF_MARGIN_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF,
    localparam int LW = lvl_w(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Wen,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  Ren,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Full,
    output logic                  Empty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty,
    output logic [LW-1:0]         Level,
    output logic                  Overflow,
    output logic                  Underflow
);

    if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_param_err
        $error("fifo_sync_flags: illegal DEPTH/threshold combination");
    end

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [LW-1:0]         level_nxt;

    // A write at Full is only legal when a pop frees the slot on the same edge.
    assign rd_acc = Ren && !Empty;
    assign wr_acc = Wen && (!Full || rd_acc);

    fifo_sync_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .Clk (Clk),
        .Rst (Rst),
        .Inc (wr_acc),
        .Ptr (wr_ptr)
    );

    fifo_sync_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .Clk (Clk),
        .Rst (Rst),
        .Inc (rd_acc),
        .Ptr (rd_ptr)
    );

    always_comb begin
        level_nxt = Level;
        if (wr_acc && !rd_acc) begin
            level_nxt = Level + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = Level - LW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_acc && !Rst) begin
            mem[wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Level       <= '0;
            Empty       <= 1'b1;
            AlmostEmpty <= 1'b1;
            Full        <= 1'b0;
            AlmostFull  <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            Level       <= level_nxt;
            Empty       <= (level_nxt == '0);
            AlmostEmpty <= (level_nxt <= AE_L);
            Full        <= (level_nxt == DEPTH_L);
            AlmostFull  <= (level_nxt >= AF_L);
            Overflow    <= Wen && !wr_acc;
            Underflow   <= Ren && !rd_acc;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign RdData = mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] rd_data_r;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_data_r <= '0;
        end else if (rd_acc) begin
            rd_data_r <= mem[rd_ptr];
        end
    end

    assign RdData = rd_data_r;
`endif

endmodule
